// File: rtl/frame_pkg.sv
// Shared definitions for the frame echo engine.
// Holds the controller state encoding and the per-frame replay modes.
package frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_CAP,
    S_RD_GAP,
    S_TX_ARM,
    S_TX_FETCH,
    S_TX_LOAD,
    S_TX_WAIT,
    S_TX_GAP
  } state_t;

  localparam logic [1:0] MODE_ECHO = 2'd0;  // replay as soon as the frame ends
  localparam logic [1:0] MODE_TICK = 2'd1;  // replay on the next time-base tick
  localparam logic [1:0] MODE_DROP = 2'd2;  // 2 and 3 both discard the frame

  function automatic logic mode_is_drop(input logic [1:0] mode);
    return (mode >= MODE_DROP);
  endfunction

endpackage

// File: rtl/frame_echo_engine_if.sv
// Byte-stream bus between the engine, the MAC receive FIFO and the MAC
// transmit port.
//   i_rdata / i_rready / o_rreq : RX FIFO data, non-empty flag, pop strobe
//   o_wdata / i_wready / o_wvalid : TX data, port ready, write strobe
// The engine connects through 'slave'; the MAC side uses 'master'.
interface frame_echo_engine_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_rdata;
  logic              i_rready;
  logic              o_rreq;
  logic [DATA_W-1:0] o_wdata;
  logic              i_wready;
  logic              o_wvalid;

  modport slave (
    input  i_rdata, i_rready, i_wready,
    output o_rreq, o_wdata, o_wvalid
  );

  modport master (
    output i_rdata, i_rready, i_wready,
    input  o_rreq, o_wdata, o_wvalid
  );
endinterface

// File: rtl/frame_buf_ram.sv
// Frame buffer: simple dual-port RAM, one write port and one synchronous
// read port (data appears the cycle after the address). The array is not
// reset.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr/o_rdata  : read port, 1-cycle latency
module frame_buf_ram #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [$clog2(BUF_DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [$clog2(BUF_DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]            o_rdata
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/frame_echo_engine.sv
// Ethernet payload echo engine. Drains a payload from the MAC RX FIFO into
// the frame buffer, ends the frame after IDLE_TIMEOUT idle cycles, then
// replays it (padded to MIN_LEN with PAD_BYTE) now, on the next time-base
// tick, or not at all, as selected by i_mode at frame end.
//   i_clk, i_rst (async, active-high)
//   i_mode      : 0 echo now, 1 echo on tick, 2/3 drop
//   bus         : RX/TX byte handshakes (see frame_echo_engine_if)
//   o_busy      : controller not idle
//   o_done      : one-cycle pulse per frame sent or dropped
//   o_frame_len : stored byte count of the last frame
//   o_overflow  : sticky until next frame start, byte lost to full buffer
//   o_frame_cnt : completed frames, wraps
//   o_tick      : one-cycle time-base pulse every TICK_DIV clocks
module frame_echo_engine
  import frame_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              BUF_DEPTH    = 256,
  parameter int              IDLE_TIMEOUT = 62,
  parameter int              MIN_LEN      = 50,
  parameter logic [DATA_W-1:0] PAD_BYTE   = '0,
  parameter int              TICK_DIV     = 50_000_000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [1:0]                 i_mode,
  frame_echo_engine_if.slave         bus,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(BUF_DEPTH):0] o_frame_len,
  output logic                       o_overflow,
  output logic [15:0]                o_frame_cnt,
  output logic                       o_tick
);

  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int LW  = AW + 1;
  // The transmit index must also reach MIN_LEN when padding past the buffer.
  localparam int MLW = $clog2(MIN_LEN + 1);
  localparam int TXW = (MLW > LW) ? MLW : LW;
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [LW-1:0]  DEPTH_V   = LW'(BUF_DEPTH);
  localparam logic [TXW-1:0] MIN_V     = TXW'(MIN_LEN);
  localparam logic [9:0]     IDLE_LAST = 10'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

  state_t            state_q, state_d;
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [9:0]        idle_q, idle_d;
  logic [LW-1:0]     len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [TXW-1:0]    tx_len_q, tx_len_d;
  logic [TXW-1:0]    rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TW-1:0]     tick_q, tick_d;

  logic              tick;
  logic              idle_expired;
  logic              tx_last;
  logic [TXW-1:0]    len_ext;
  logic              ram_we;
  logic              done;
  logic [DATA_W-1:0] ram_rdata;

  assign tick         = (tick_q == TICK_LAST);
  assign idle_expired = (idle_q == IDLE_LAST);
  assign tx_last      = (rd_idx_q == tx_len_q);
  assign len_ext      = TXW'(len_q);

  frame_buf_ram #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (bus.i_rdata),
    .i_raddr (rd_idx_q[AW-1:0]),
    .o_rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (bus.i_rready) state_d = S_RD_REQ;
      S_RD_REQ:   state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_RD_GAP;
      // A byte showing up on the last idle cycle still extends the frame.
      S_RD_GAP: begin
        if (bus.i_rready)      state_d = S_RD_REQ;
        else if (idle_expired) state_d = S_TX_ARM;
      end
      S_TX_ARM: begin
        if (mode_is_drop(mode_q))                             state_d = S_IDLE;
        else if (mode_q == MODE_ECHO || (mode_q == MODE_TICK && tick)) state_d = S_TX_FETCH;
      end
      S_TX_FETCH: state_d = S_TX_LOAD;
      S_TX_LOAD:  state_d = S_TX_WAIT;
      S_TX_WAIT:  if (bus.i_wready) state_d = S_TX_GAP;
      S_TX_GAP:   state_d = tx_last ? S_IDLE : S_TX_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.o_rreq   = (state_q == S_RD_REQ);
    bus.o_wvalid = (state_q == S_TX_WAIT) && bus.i_wready;
    ram_we       = (state_q == S_RD_CAP) && (wr_ptr_q < DEPTH_V);
    done         = ((state_q == S_TX_ARM) && mode_is_drop(mode_q)) ||
                   ((state_q == S_TX_GAP) && tx_last);
    o_busy       = (state_q != S_IDLE);
    o_done       = done;
  end

  // Datapath next values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    idle_d   = idle_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    tx_len_d = tx_len_q;
    rd_idx_d = rd_idx_q;
    wdata_d  = wdata_q;
    tick_d   = tick ? '0 : tick_q + 1'b1;

    if (done) cnt_d = cnt_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_rready) begin
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
          idle_d   = '0;
        end
      end
      S_RD_CAP: begin
        if (ram_we) wr_ptr_d = wr_ptr_q + 1'b1;
        else        ovf_d    = 1'b1;
        idle_d = '0;
      end
      S_RD_GAP: begin
        if (!bus.i_rready) begin
          if (idle_expired) begin
            len_d  = wr_ptr_q;
            mode_d = i_mode;
          end else begin
            idle_d = idle_q + 10'd1;
          end
        end
      end
      S_TX_ARM: begin
        tx_len_d = (len_ext > MIN_V) ? len_ext : MIN_V;
        rd_idx_d = '0;
      end
      S_TX_LOAD: begin
        wdata_d = (rd_idx_q < len_ext) ? ram_rdata : PAD_BYTE;
      end
      S_TX_WAIT: begin
        if (bus.i_wready) rd_idx_d = rd_idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      idle_q   <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= MODE_ECHO;
      tx_len_q <= '0;
      rd_idx_q <= '0;
      wdata_q  <= '0;
      tick_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      idle_q   <= idle_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      tx_len_q <= tx_len_d;
      rd_idx_q <= rd_idx_d;
      wdata_q  <= wdata_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.o_wdata = wdata_q;
  assign o_frame_len = len_q;
  assign o_overflow  = ovf_q;
  assign o_frame_cnt = cnt_q;
  assign o_tick      = tick;

endmodule
